// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Single-clock SPI-style frame master. A frame is one select bit
//            (LEAD), a 10-bit {cmd,wdata} word shifted MSB first (SHIFT), and
//            for read-data frames a turnaround (TURN) followed by an 8-bit
//            receive window (RECV). Every frame ends with a select-high
//            guard interval (GAP) that carries the one-cycle done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  clock, all logic on the rising edge
//   rst      in   1  synchronous active-high reset
//   start_i  in   1  frame request, sampled only while idle
//   cmd_i    in   2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   wdata_i  in   8  frame payload (ignored for rd-data)
//   busy_o   out  1  frame in progress
//   done_o   out  1  one-cycle pulse in the first GAP cycle
//   rdata_o  out  8  byte captured by the most recent rd-data frame
//   ss_n_o   out  1  slave select, active low
//   mosi_o   out  1  serial data to slave, MSB first
//   miso_i   in   1  serial data from slave, MSB first
// Parameters
//   TURN_CYC  turnaround cycles before the receive window (1..7)
//   GAP_CYC   select-high cycles after each frame (1..7)
// ============================================================================
module spi_master #(
    parameter int TURN_CYC = 1,
    parameter int GAP_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] cmd_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       ss_n_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TURN  = 3'd3,
        RECV  = 3'd4,
        GAP   = 3'd5
    } state_t;

    // Terminal counts: each timed state exits when the counter reaches these.
    localparam logic [3:0] c_SHIFT_LAST = 4'd9;
    localparam logic [3:0] c_RECV_LAST  = 4'd7;
    localparam logic [3:0] c_TURN_LAST  = 4'(TURN_CYC - 1);
    localparam logic [3:0] c_GAP_LAST   = 4'(GAP_CYC - 1);

    state_t     state_q,    state_d;
    logic [3:0] cnt_q,      cnt_d;
    logic [9:0] frame_q,    frame_d;
    logic       rd_frame_q, rd_frame_d;
    logic [7:0] rx_q,       rx_d;
    logic [7:0] rdata_q,    rdata_d;

    // Output registers, loaded from the decode of the next state so that the
    // pins come straight from flops and cannot glitch mid-frame.
    logic       ss_n_q,     ss_n_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       mosi_q,     mosi_d;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        rd_frame_d = rd_frame_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = LEAD;
                    cnt_d      = 4'd0;
                    frame_d    = {cmd_i, wdata_i};
                    // The read/turnaround decision is captured here so later
                    // cmd_i activity cannot alter the frame shape.
                    rd_frame_d = (cmd_i == 2'b11);
                    rx_d       = 8'h00;
                end
            end

            LEAD: begin
                state_d = SHIFT;
                cnt_d   = 4'd0;
            end

            SHIFT: begin
                if (cnt_q == c_SHIFT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = rd_frame_q ? TURN : GAP;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    // Frame word shifts left; bit 9 is always the next bit out.
                    frame_d = {frame_q[8:0], 1'b0};
                end
            end

            TURN: begin
                if (cnt_q == c_TURN_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = RECV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            RECV: begin
                rx_d = {rx_q[6:0], miso_i};
                if (cnt_q == c_RECV_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = GAP;
                    // Publish the byte including the sample taken on this edge.
                    rdata_d = {rx_q[6:0], miso_i};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            GAP: begin
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        ss_n_d = !((state_d == LEAD) || (state_d == SHIFT) ||
                   (state_d == TURN) || (state_d == RECV));
        busy_d = (state_d != IDLE);
        // Only the transition into GAP pulses done, so a long GAP stays quiet.
        done_d = (state_d == GAP) && (state_q != GAP);
        // LEAD repeats the select bit cmd[1], which is also frame bit 9.
        mosi_d = ((state_d == LEAD) || (state_d == SHIFT)) ? frame_d[9] : 1'b0;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            frame_q    <= 10'd0;
            rd_frame_q <= 1'b0;
            rx_q       <= 8'h00;
            rdata_q    <= 8'h00;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            rd_frame_q <= rd_frame_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign ss_n_o  = ss_n_q;
    assign mosi_o  = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master with an SPI slave + RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int TURN = 1;
    localparam int GAP  = 1;
    localparam int NCAP = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ss_n;
    logic       mosi;
    logic       miso = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master #(
        .TURN_CYC (TURN),
        .GAP_CYC  (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .cmd_i   (cmd),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .rdata_o (rdata),
        .ss_n_o  (ss_n),
        .mosi_o  (mosi),
        .miso_i  (miso)
    );

    // Default content of a never-written RAM location.
    function automatic logic [7:0] mem_init(input logic [7:0] a);
        return 8'(a * 8'd29 + 8'd7);
    endfunction

    // ------------------------------------------------------------------------
    // SPI slave + RAM. Counts select-low cycles, collects the first 11 MOSI
    // bits, serves read-data bytes in the receive window and commits address
    // and write commands when select rises after a complete 11-cycle frame.
    // ------------------------------------------------------------------------
    logic [7:0]  slv_mem [256];
    bit          slv_wr  [256];
    logic [7:0]  slv_addr = 8'h00;
    logic [10:0] slv_bits = 11'd0;
    int          slv_b    = 0;

    always @(negedge clk) begin : p_slave
        logic [7:0] byte_v;
        int         idx;
        if (ss_n === 1'b0) begin
            if (slv_b < 11) slv_bits = {slv_bits[9:0], mosi};
            byte_v = slv_wr[slv_addr] ? slv_mem[slv_addr] : mem_init(slv_addr);
            idx    = slv_b - (11 + TURN);
            if (slv_b >= 11 && slv_bits[9:8] == 2'b11 && idx >= 0 && idx < 8)
                miso = byte_v[7 - idx];
            else
                miso = 1'($urandom);
            slv_b++;
        end else begin
            if (slv_b == 11) begin
                case (slv_bits[9:8])
                    2'b00, 2'b10: slv_addr = slv_bits[7:0];
                    2'b01: begin
                        slv_mem[slv_addr] = slv_bits[7:0];
                        slv_wr[slv_addr]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            slv_b = 0;
            miso  = 1'($urandom);
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: RAM behaviour per issued command, and frame waveforms
    // ------------------------------------------------------------------------
    logic [7:0] ref_mem [256];
    logic [7:0] ref_addr  = 8'h00;
    logic [7:0] ref_rdata = 8'h00;

    task automatic ref_update(input logic [1:0] c, input logic [7:0] d);
        case (c)
            2'b00, 2'b10: ref_addr = d;
            2'b01:        ref_mem[ref_addr] = d;
            default:      ref_rdata = ref_mem[ref_addr];
        endcase
    endtask

    function automatic int frame_len(input logic [1:0] c);
        return (c == 2'b11) ? 19 + TURN : 11;
    endfunction

    // Expected per-cycle SS_n / MOSI / done / busy, bit k = cycle k after the
    // start edge, covering the frame, its gap and the first idle cycle.
    function automatic void expect_frame(input logic [1:0] c, input logic [7:0] d,
                                         output logic [NCAP:0] x_ss, output logic [NCAP:0] x_mo,
                                         output logic [NCAP:0] x_dn, output logic [NCAP:0] x_bz);
        int          len;
        logic [10:0] bits;
        len  = frame_len(c);
        bits = {c[1], c, d};
        x_ss = '1; x_mo = '0; x_dn = '0; x_bz = '0;
        for (int k = 1; k <= len + GAP + 1; k++) begin
            x_ss[k] = (k > len);
            x_bz[k] = (k <= len + GAP);
            x_dn[k] = (k == len + 1);
            if (k <= 11) x_mo[k] = bits[11 - k];
        end
    endfunction

    // ------------------------------------------------------------------------
    // Frame driver / capture. Called at a negedge; returns at the negedge of
    // the first idle cycle, so a following call starts at the earliest edge.
    // ------------------------------------------------------------------------
    logic [NCAP:0] cap_ss, cap_mo, cap_dn, cap_bz;
    logic [7:0]    cap_rd [0:NCAP];
    logic [NCAP:0] e_ss, e_mo, e_dn, e_bz;

    task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                             input bit hold, input int pulse_at);
        int ncyc;
        ncyc  = frame_len(c) + GAP + 1;
        cmd   = c;
        wdata = d;
        start = 1'b1;
        @(posedge clk);
        cap_ss = '1; cap_mo = '0; cap_dn = '0; cap_bz = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            cap_ss[k] = ss_n;
            cap_mo[k] = mosi;
            cap_dn[k] = done;
            cap_bz[k] = busy;
            cap_rd[k] = rdata;
            if (!hold) start = (k == pulse_at);
            cmd   = 2'($urandom);
            wdata = 8'($urandom);
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        bit idle_ok;
        rst = 1'b1; start = 1'b1; cmd = 2'b11; wdata = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ss_n !== 1'b1)   begin n_fail++; $display("FAIL rst_ss_n: got %b expected 1", ss_n); end
        n_checks++; if (mosi !== 1'b0)   begin n_fail++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
        rst = 1'b0; start = 1'b0;
        idle_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || ss_n !== 1'b1) idle_ok = 1'b0;
        end
        n_checks++; if (!idle_ok) begin n_fail++; $display("FAIL rst_start_ignored: got frame expected idle"); end
    endtask

    task automatic test_write_addr();
        run_frame(2'b00, 8'hA5, 1'b0, 0);
        ref_update(2'b00, 8'hA5);
        n_checks++; if (cap_mo[11:1] !== 11'b10100101000) begin n_fail++; $display("FAIL wa_mosi: got %b expected 10100101000", cap_mo[11:1]); end
        n_checks++; if (cap_ss[13:1] !== 13'b1100000000000) begin n_fail++; $display("FAIL wa_ss_n: got %b expected 1100000000000", cap_ss[13:1]); end
        n_checks++; if (cap_dn[13:1] !== 13'b0100000000000) begin n_fail++; $display("FAIL wa_done: got %b expected 0100000000000", cap_dn[13:1]); end
        n_checks++; if (cap_bz[13:1] !== 13'b0111111111111) begin n_fail++; $display("FAIL wa_busy: got %b expected 0111111111111", cap_bz[13:1]); end
        n_checks++; if (cap_rd[13] !== 8'h00) begin n_fail++; $display("FAIL wa_rdata_held: got %h expected 00", cap_rd[13]); end
    endtask

    task automatic test_read_data();
        run_frame(2'b01, 8'h3C, 1'b0, 0);
        ref_update(2'b01, 8'h3C);
        expect_frame(2'b01, 8'h3C, e_ss, e_mo, e_dn, e_bz);
        n_checks++; if ({cap_ss, cap_mo, cap_dn, cap_bz} !== {e_ss, e_mo, e_dn, e_bz}) begin
            n_fail++; $display("FAIL rd_wr_wave: got %h expected %h", {cap_ss, cap_mo, cap_dn, cap_bz}, {e_ss, e_mo, e_dn, e_bz}); end
        run_frame(2'b11, 8'h00, 1'b0, 0);
        ref_update(2'b11, 8'h00);
        expect_frame(2'b11, 8'h00, e_ss, e_mo, e_dn, e_bz);
        n_checks++; if ({cap_ss, cap_mo, cap_dn, cap_bz} !== {e_ss, e_mo, e_dn, e_bz}) begin
            n_fail++; $display("FAIL rd_wave: got %h expected %h", {cap_ss, cap_mo, cap_dn, cap_bz}, {e_ss, e_mo, e_dn, e_bz}); end
        n_checks++; if (cap_ss[21:1] !== 21'h100000) begin n_fail++; $display("FAIL rd_ss_n: got %h expected 100000", cap_ss[21:1]); end
        n_checks++; if (cap_dn[21] !== 1'b1) begin n_fail++; $display("FAIL rd_done21: got %b expected 1", cap_dn[21]); end
        n_checks++; if (cap_rd[20] !== 8'h00) begin n_fail++; $display("FAIL rd_rdata20: got %h expected 00", cap_rd[20]); end
        n_checks++; if (cap_rd[21] !== 8'h3C) begin n_fail++; $display("FAIL rd_rdata21: got %h expected 3c", cap_rd[21]); end
    endtask

    task automatic test_ram_roundtrip();
        logic [1:0] cs [4];
        logic [7:0] ds [4];
        cs[0] = 2'b00; ds[0] = 8'h10;
        cs[1] = 2'b01; ds[1] = 8'h5A;
        cs[2] = 2'b10; ds[2] = 8'h10;
        cs[3] = 2'b11; ds[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            run_frame(cs[i], ds[i], 1'b0, 0);
            ref_update(cs[i], ds[i]);
            expect_frame(cs[i], ds[i], e_ss, e_mo, e_dn, e_bz);
            n_checks++; if ({cap_ss, cap_mo, cap_dn, cap_bz} !== {e_ss, e_mo, e_dn, e_bz}) begin
                n_fail++; $display("FAIL rt_wave%0d: got %h expected %h", i, {cap_ss, cap_mo, cap_dn, cap_bz}, {e_ss, e_mo, e_dn, e_bz}); end
        end
        n_checks++; if (rdata !== 8'h5A) begin n_fail++; $display("FAIL rt_rdata: got %h expected 5a", rdata); end
    endtask

    task automatic test_start_ignored();
        bit         idle_ok;
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            // Pulse at frame cycle 5, then in the done cycle of a write frame.
            run_frame((i == 0) ? 2'b01 : 2'b00, d, 1'b0, (i == 0) ? 5 : 12);
            ref_update((i == 0) ? 2'b01 : 2'b00, d);
            expect_frame((i == 0) ? 2'b01 : 2'b00, d, e_ss, e_mo, e_dn, e_bz);
            n_checks++; if ({cap_ss, cap_mo, cap_dn, cap_bz} !== {e_ss, e_mo, e_dn, e_bz}) begin
                n_fail++; $display("FAIL ign_wave%0d: got %h expected %h", i, {cap_ss, cap_mo, cap_dn, cap_bz}, {e_ss, e_mo, e_dn, e_bz}); end
            idle_ok = 1'b1;
            repeat (25) begin
                @(negedge clk);
                if (ss_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
            end
            n_checks++; if (!idle_ok) begin n_fail++; $display("FAIL ign_extra_frame%0d: got activity expected idle", i); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] c;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            c = (i == 2) ? 2'b11 : 2'($urandom);
            d = 8'($urandom);
            run_frame(c, d, (i < 3), 0);
            ref_update(c, d);
            expect_frame(c, d, e_ss, e_mo, e_dn, e_bz);
            n_checks++; if ({cap_ss, cap_mo, cap_dn, cap_bz} !== {e_ss, e_mo, e_dn, e_bz}) begin
                n_fail++; $display("FAIL b2b_wave%0d: got %h expected %h", i, {cap_ss, cap_mo, cap_dn, cap_bz}, {e_ss, e_mo, e_dn, e_bz}); end
            n_checks++; if (rdata !== ref_rdata) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, rdata, ref_rdata); end
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            d = c[0] ? 8'($urandom) : {4'h0, 4'($urandom)};
            run_frame(c, d, 1'b0, 0);
            ref_update(c, d);
            expect_frame(c, d, e_ss, e_mo, e_dn, e_bz);
            n_checks++; if ({cap_ss, cap_mo, cap_dn, cap_bz} !== {e_ss, e_mo, e_dn, e_bz}) begin
                n_fail++; $display("FAIL rnd_wave%0d: got %h expected %h", i, {cap_ss, cap_mo, cap_dn, cap_bz}, {e_ss, e_mo, e_dn, e_bz}); end
            n_checks++; if (rdata !== ref_rdata) begin n_fail++; $display("FAIL rnd_rdata%0d: got %h expected %h", i, rdata, ref_rdata); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        bit low_ok, saw_done, idle_ok;
        run_frame(2'b00, 8'h77, 1'b0, 0); ref_update(2'b00, 8'h77);
        run_frame(2'b01, 8'hC3, 1'b0, 0); ref_update(2'b01, 8'hC3);
        run_frame(2'b10, 8'h77, 1'b0, 0); ref_update(2'b10, 8'h77);
        run_frame(2'b11, 8'h00, 1'b0, 0); ref_update(2'b11, 8'h00);
        n_checks++; if (rdata !== 8'hC3) begin n_fail++; $display("FAIL rm_pre_rdata: got %h expected c3", rdata); end
        cmd = 2'b11; wdata = 8'($urandom); start = 1'b1;
        @(posedge clk);
        low_ok = 1'b1; saw_done = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (ss_n !== 1'b0) low_ok = 1'b0;
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (!low_ok) begin n_fail++; $display("FAIL rm_frame_low: got select high expected low in cycles 1..15"); end
        n_checks++; if (ss_n !== 1'b1)   begin n_fail++; $display("FAIL rm_ss_n: got %b expected 1", ss_n); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
        n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rm_rdata: got %h expected 00", rdata); end
        rst = 1'b0;
        ref_rdata = 8'h00;
        idle_ok = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            if (ss_n !== 1'b1) idle_ok = 1'b0;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL rm_no_done: got done pulse expected none"); end
        n_checks++; if (!idle_ok || rdata !== 8'h00) begin n_fail++; $display("FAIL rm_after: got ss_n ok=%0b rdata %h expected 1 00", idle_ok, rdata); end
        // Recovery: a fresh read-data frame returns the stored byte.
        run_frame(2'b11, 8'h00, 1'b0, 0); ref_update(2'b11, 8'h00);
        n_checks++; if (rdata !== ref_rdata) begin n_fail++; $display("FAIL rm_recover: got %h expected %h", rdata, ref_rdata); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd = 2'b00; wdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
        test_reset();
        test_write_addr();
        test_read_data();
        test_ram_roundtrip();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter TURN_CYC, default 1: cycles between the last MOSI bit and the first MISO bit of a read-data frame, range 1..7.
REQ-002 Parameter GAP_CYC, default 1: minimum cycles SS_n stays high between frames, range 1..7.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one frame; sampled only when busy=0.
REQ-006 cmd  input  2  frame command: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
REQ-007 wdata  input  8  frame payload (address or data; don't-care for cmd=11).
REQ-008 busy  output  1  frame in progress; start ignored while high.
REQ-009 done  output  1  one-cycle pulse at frame completion.
REQ-010 rdata  output  8  byte received in the last read-data frame.
REQ-011 SS_n  output  1  slave select, active-low.
REQ-012 MOSI  output  1  serial data to slave, MSB first.
REQ-013 MISO  input  1  serial data from slave, MSB first.

Function
REQ-014 States SHALL be IDLE, LEAD, SHIFT, TURN, RECV, GAP; reset state IDLE.
REQ-015 IDLE: start=1 at edge N latches {cmd,wdata} into a 10-bit frame register; state LEAD, SS_n=0, busy=1 from cycle N+1.
REQ-016 LEAD lasts 1 cycle with MOSI=cmd[1] (select bit), then SHIFT.
REQ-017 SHIFT lasts exactly 10 cycles, MOSI = frame[9] down to frame[0], one bit per cycle; 4-bit counter tracks bits.
REQ-018 After SHIFT, cmd 00/01/10 -> GAP; cmd 11 -> TURN.
REQ-019 TURN lasts TURN_CYC cycles, SS_n=0, MOSI=0.
REQ-020 RECV lasts exactly 8 cycles; MISO sampled each rising edge into a shift register, first sample = bit 7.
REQ-021 On RECV exit, rdata loads the full byte in the same edge; rdata is otherwise held (write/read-addr frames leave it unchanged).
REQ-022 GAP lasts GAP_CYC cycles with SS_n=1, MOSI=0; done=1 only in the first GAP cycle; then IDLE, busy=0.
REQ-023 SS_n low duration: 11 cycles for cmd 00/01/10; 19+TURN_CYC cycles for cmd 11; SS_n never glitches high mid-frame.
REQ-024 MOSI SHALL be 0 whenever not in LEAD or SHIFT.
REQ-025 start asserted while busy=1 (including the done cycle) SHALL be dropped, not queued; cmd/wdata changes mid-frame have no effect.
REQ-026 Earliest next frame: start sampled in the first IDLE cycle after GAP; SS_n back-to-back high time = GAP_CYC+1 cycles minimum.

Reset
REQ-027 rst=1 at any edge SHALL force: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rdata=8'h00, counters 0.
REQ-028 Reset mid-frame SHALL abort with no done pulse; rdata not updated with partial data.
REQ-029 start sampled in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-030 Write-addr: cmd=00, wdata=8'hA5, start at edge 0 -> SS_n low cycles 1..11, MOSI 0,0,0,1,0,1,0,0,1,0,1, done at cycle 12, busy low cycle 13.
REQ-031 Read-data: cmd=11, TURN_CYC=1, MISO model drives 8'h3C in cycles 13..20 -> SS_n low cycles 1..20, done cycle 21, rdata=8'h3C from cycle 21.
REQ-032 Full RAM round trip with spi slave+RAM: write-addr 8'h10, write-data 8'h5A, read-addr 8'h10, read-data -> rdata=8'h5A.
REQ-033 start pulsed at cycle 5 of a frame -> ignored, exactly one done, no extra SS_n frame.
REQ-034 rst=1 at cycle 15 of a read-data frame -> SS_n=1 next cycle, no done, rdata=8'h00.
REQ-035 Back-to-back: start held high continuously, GAP_CYC=1 -> SS_n high exactly 2 cycles between frames, each frame bit-exact.
